// File: rtl/hazard_stall_controller_pkg.sv
// Shared constants for the hazard/stall controller: MIPS opcodes, FSM state
// encoding and the hard-wired zero register index.
package hazard_stall_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [4:0] REG_NOP  = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Combinational load-use hazard detection and immediate-extension decode
// for the instruction currently in ID.
module hazard_detect
    import hazard_stall_controller_pkg::*;
(
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_rt,
    input  logic       ex_mem_read,
    output logic       hazard,
    output logic       ext_zero
);

    logic id_uses_rt;

    always_comb begin
        id_uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
                     (id_opcode == OP_BNE)   || (id_opcode == OP_SW);
        // A load targeting $zero never produces a value worth waiting for.
        hazard     = ex_mem_read && (ex_rt != REG_NOP) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        ext_zero   = (id_opcode == OP_ANDI) || (id_opcode == OP_ORI) ||
                     (id_opcode == OP_XORI);
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// immediate-extension select. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES    = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int CNT_W               = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_read,
    input  logic        mem_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        ext_zero,
    output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             ext_zero_raw;
    logic             pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c, exmem_flush_c;

    hazard_detect u_hazard_detect (
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rt       (ex_rt),
        .ex_mem_read (ex_mem_read),
        .hazard      (hazard),
        .ext_zero    (ext_zero_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;

        // A taken branch overrides everything, including a stall in progress.
        if (mem_branch_taken) begin
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        pc_write_c   = 1'b0;
                        ifid_write_c = 1'b0;
                        idex_flush_c = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end
                end
                ST_STALL: begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                ST_FLUSH: begin
                    // ID holds a squashed instruction, so its hazard is ignored.
                    ifid_flush_c = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = pc_write_c;
        ifid_write  = ifid_write_c;
        ifid_flush  = ifid_flush_c;
        idex_flush  = idex_flush_c;
        exmem_flush = exmem_flush_c;
        ext_zero    = ext_zero_raw;
        ctrl_state  = state_q;
        // Hold the pipeline frozen and bubbled for as long as reset is low.
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            ext_zero    = 1'b0;
            ctrl_state  = ST_RUN;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q + (pc_write ? 32'd0 : 32'd1);
        flush_count_d = flush_count_q + (mem_branch_taken ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: a default instance and a 3-bubble /
// 2-flush instance driven together and compared against a cycle-level model.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, mem_branch_taken;

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, ext_zero, ctrl_state[1:0]}
    logic [7:0] obs0, obs1;

    int lub [2] = '{1, 3};
    int bfc [2] = '{1, 2};
    int pend_stall [2];
    int pend_flush [2];
    int exp_sc [2];
    int exp_fc [2];
    int checks = 0;
    int errors = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    always #5 clk = ~clk;

    hazard_stall_controller u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
        .pc_write(obs0[7]), .ifid_write(obs0[6]), .ifid_flush(obs0[5]),
        .idex_flush(obs0[4]), .exmem_flush(obs0[3]), .ext_zero(obs0[2]),
        .ctrl_state(obs0[1:0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc0), .flush_count(fc0)
`endif
    );

    hazard_stall_controller #(
        .LOAD_USE_BUBBLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
        .pc_write(obs1[7]), .ifid_write(obs1[6]), .ifid_flush(obs1[5]),
        .idex_flush(obs1[4]), .exmem_flush(obs1[3]), .ext_zero(obs1[2]),
        .ctrl_state(obs1[1:0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        bit uses_rt;
        uses_rt = (id_opcode == 6'b000000) || (id_opcode == 6'b000100) ||
                  (id_opcode == 6'b000101) || (id_opcode == 6'b101011);
        return ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

    // Expected outputs from the number of owed stall/flush cycles, not an FSM.
    function automatic logic [7:0] model_outs(int k);
        logic [4:0] ctl;
        logic       ez;
        logic [1:0] st;
        if (!rst_n) return 8'b00111_0_00;
        ez = (id_opcode == 6'b001100) || (id_opcode == 6'b001101) || (id_opcode == 6'b001110);
        st = (pend_flush[k] > 0) ? 2'd2 : (pend_stall[k] > 0) ? 2'd1 : 2'd0;
        if (mem_branch_taken)        ctl = 5'b11111;
        else if (pend_flush[k] > 0)  ctl = 5'b11100;
        else if (pend_stall[k] > 0)  ctl = 5'b00010;
        else if (model_hazard())     ctl = 5'b00010;
        else                         ctl = 5'b11000;
        return {ctl, ez, st};
    endfunction

    task automatic tick();
        logic [7:0] e;
        logic [7:0] o;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = model_outs(k);
            o = (k == 0) ? obs0 : obs1;
            check($sformatf("ctl%0d", k),   {27'd0, o[7:3]}, {27'd0, e[7:3]});
            check($sformatf("ext%0d", k),   {31'd0, o[2]},   {31'd0, e[2]});
            check($sformatf("state%0d", k), {30'd0, o[1:0]}, {30'd0, e[1:0]});
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pend_stall[k] = 0;
                pend_flush[k] = 0;
                exp_sc[k]     = 0;
                exp_fc[k]     = 0;
            end else begin
                e = model_outs(k);
                if (!e[7]) exp_sc[k]++;
                if (mem_branch_taken) exp_fc[k]++;
                if (mem_branch_taken) begin
                    pend_flush[k] = bfc[k] - 1;
                    pend_stall[k] = 0;
                end else if (pend_flush[k] > 0) begin
                    pend_flush[k]--;
                end else if (pend_stall[k] > 0) begin
                    pend_stall[k]--;
                end else if (model_hazard()) begin
                    pend_stall[k] = lub[k] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] xrt, input logic xrd, input logic br);
        id_opcode        = op;
        id_rs            = rs;
        id_rt            = rt;
        ex_rt            = xrt;
        ex_mem_read      = xrd;
        mem_branch_taken = br;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(6'b001000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    endtask

    task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_sc0"}, sc0, exp_sc[0]);
        check({tag, "_fc0"}, fc0, exp_fc[0]);
        check({tag, "_sc1"}, sc1, exp_sc[1]);
        check({tag, "_fc1"}, fc1, exp_fc[1]);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    logic [5:0] ops [9];

    initial begin
        ops = '{6'b000000, 6'b000100, 6'b000101, 6'b101011, 6'b100011,
                6'b001100, 6'b001101, 6'b001110, 6'b001000};
        pend_stall = '{0, 0};
        pend_flush = '{0, 0};
        exp_sc     = '{0, 0};
        exp_fc     = '{0, 0};

        // Reset held for three cycles, then released into an idle pipeline.
        rst_n = 1'b0;
        drive(6'b001100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(6'b001100, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0);
        drive(6'b000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        idle(2);

        // Load-use through rs (lw in ID), then the same with ex_rt = $zero.
        drive(6'b100011, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0);
        idle(4);
        drive(6'b100011, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0);
        idle(1);

        // sw uses rt: hazard through rt; lw in ID does not.
        drive(6'b101011, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0);
        idle(4);
        drive(6'b100011, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0);
        idle(1);

        // Taken branch during the second stall cycle.
        drive(6'b000000, 5'd8, 5'd2, 5'd8, 1'b1, 1'b0);
        drive(6'b001000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        idle(4);

        // Taken branch together with a hazard, then a hazard during FLUSH.
        drive(6'b000000, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1);
        drive(6'b000000, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0);
        idle(4);
        check_perf("directed");

        // Immediate extension sweep.
        drive(6'b001100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        drive(6'b001101, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        drive(6'b001110, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        drive(6'b001000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        drive(6'b100011, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

        // Reset asserted mid-stall aborts to the reset outputs.
        drive(6'b000000, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(6'b000000, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Reset asserted mid-flush.
        drive(6'b000000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        check_perf("after_reset");

        // Randomized traffic with a small register pool so hazards are common.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(ops[$urandom_range(0, 8)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        rst_n = 1'b1;
        idle(4);
        check_perf("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
